// File: rtl/quadrature_decoder.sv
// Quadrature decoder: 2-FF synchronised A/B channels decoded into a signed x4 position,
// direction, distance-since-clear with limit flag, and a sticky illegal-transition flag.
// Optional per-channel glitch filter is built when QDEC_FILTER_EN is defined.
`timescale 1ns/1ps
module quadrature_decoder #(
  parameter int COUNT_W    = 32,
  parameter int DIST_W     = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_in,
  input  logic               b_in,
  input  logic               clear,
  input  logic [DIST_W-1:0]  limit_value,
  output logic [COUNT_W-1:0] step_count,
  output logic               direction,
  output logic               step_pulse,
  output logic [DIST_W-1:0]  distance,
  output logic               limit_reached,
  output logic               illegal_err
);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("quadrature_decoder: FILTER_LEN must be at least 1");
  end

  // AB pairs are packed as {a, b}.
  logic [1:0] raw_ab;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] ab_cur;
  logic [1:0] ab_prev_q, ab_prev_d;
  logic       init_q, init_d;

  assign raw_ab = {a_in, b_in};

  // init_q is low for the first cycle after reset release; every input-path
  // register then loads the live pin state so no edge is seen at start-up.
  always_comb begin
    init_d  = 1'b1;
    sync1_d = init_q ? raw_ab  : raw_ab;
    sync2_d = init_q ? sync1_q : raw_ab;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= 1'b0;
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      init_q  <= init_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // A channel propagates only after FILTER_LEN consecutive samples differ
  // from the filtered value; any return to the old level restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (!init_q) begin
        filt_d[i] = raw_ab[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign ab_cur = filt_q;
`else
  assign ab_cur = sync2_q;
`endif

  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic               direction_q, direction_d;
  logic               step_pulse_q, step_pulse_d;
  logic [DIST_W-1:0]  distance_q, distance_d;
  logic               limit_q, limit_d;
  logic               illegal_q, illegal_d;
  logic [1:0]         pos_cur, pos_prev;
  logic               fwd, rev, jump;

  // Gray {a,b} 00,10,11,01 maps to positions 0,1,2,3 around the cycle.
  assign pos_cur  = {ab_cur[0], ab_cur[1] ^ ab_cur[0]};
  assign pos_prev = {ab_prev_q[0], ab_prev_q[1] ^ ab_prev_q[0]};
  assign fwd      = (pos_cur == pos_prev + 2'd1);
  assign rev      = (pos_prev == pos_cur + 2'd1);
  assign jump     = (ab_cur != ab_prev_q) && !fwd && !rev;

  always_comb begin
    step_count_d = step_count_q;
    direction_d  = direction_q;
    step_pulse_d = 1'b0;
    distance_d   = distance_q;
    illegal_d    = illegal_q;
    ab_prev_d    = ab_cur;
    limit_d      = (limit_value != '0) && (distance_q >= limit_value);
    if (!init_q) begin
      ab_prev_d = raw_ab;
      limit_d   = limit_q;
    end else if (clear) begin
      step_count_d = '0;
      distance_d   = '0;
      limit_d      = 1'b0;
      illegal_d    = 1'b0;
    end else if (fwd || rev) begin
      step_count_d = fwd ? step_count_q + 1'b1 : step_count_q - 1'b1;
      direction_d  = rev;
      step_pulse_d = 1'b1;
      if (distance_q != '1) begin
        distance_d = distance_q + 1'b1;
      end
    end else if (jump) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_prev_q    <= 2'b00;
      step_count_q <= '0;
      direction_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      distance_q   <= '0;
      limit_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      ab_prev_q    <= ab_prev_d;
      step_count_q <= step_count_d;
      direction_q  <= direction_d;
      step_pulse_q <= step_pulse_d;
      distance_q   <= distance_d;
      limit_q      <= limit_d;
      illegal_q    <= illegal_d;
    end
  end

  assign step_count    = step_count_q;
  assign direction     = direction_q;
  assign step_pulse    = step_pulse_q;
  assign distance      = distance_q;
  assign limit_reached = limit_q;
  assign illegal_err   = illegal_q;

endmodule
